// File: rtl/adc_ddr3_writer_if.sv
// MIG user-interface write bundle: command channel (addr/cmd/en/rdy) and
// write-data channel (data/wren/end/rdy).
// master : the writer engine, drives command and write data, receives the ready signals
// slave  : the MIG side, receives command and write data, drives the ready signals
interface adc_ddr3_writer_if;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/adc_ddr3_writer.sv
// Capture engine between the ADC sample stream and the DDR3 MIG user port.
// Packs 8 x 12-bit samples per 128-bit word, buffers words in a small FIFO
// and writes them to consecutive MIG addresses starting at BASE_ADDR.
// Ports:
//   ui_clk, ui_clk_sync_rst   clock and synchronous active-high reset
//   init_calib_complete       MIG calibration done; start ignored while low
//   start, sample_count       run request pulse and run length (samples)
//   adc_data, adc_valid       sample stream
//   mig                       MIG command + write-data channels (master side)
//   busy, done, overflow      run status; overflow is sticky until next run
//   words_written             words fully accepted by the MIG in this run
//
// state   | meaning
// IDLE    | waiting for an accepted start
// CAPTURE | consuming samples, writing words as they become available
// DRAIN   | all samples consumed, flushing remaining words to the MIG
module adc_ddr3_writer #(
  parameter logic [27:0] BASE_ADDR  = 28'h0000000,
  parameter int          ADDR_STEP  = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        ui_clk,
  input  logic        ui_clk_sync_rst,
  input  logic        init_calib_complete,
  input  logic        start,
  input  logic [15:0] sample_count,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  adc_ddr3_writer_if.master mig,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] words_written
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t         state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     slot_q;
  logic [127:0]   pack_q;
  logic           push_q;
  logic [127:0]   push_data_q;
  logic [127:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [AW:0]    fill_q, fill_d;
  logic           pres_q;
  logic           app_en_q, wren_q;
  logic [127:0]   wdf_data_q;
  logic [27:0]    addr_q;
  logic           busy_q, done_q, overflow_q;
  logic [15:0]    words_q;

  logic [127:0]   word_d;
  logic           pop_d, push_ok_d, full_d;

  // Current packing word with this cycle's sample merged into its slot.
  always_comb begin
    word_d = pack_q;
    word_d[{slot_q, 4'b0000} +: 16] = {4'h0, adc_data};
  end

  // A handshake already completed in an earlier cycle has its strobe low,
  // so a low strobe while presenting counts as finished.
  assign pop_d     = pres_q && (!app_en_q || mig.app_rdy) && (!wren_q || mig.app_wdf_rdy);
  assign full_d    = (fill_q == (AW+1)'(FIFO_DEPTH));
  assign push_ok_d = push_q && (!full_d || pop_d);

  always_comb begin
    fill_d = fill_q;
    if (push_ok_d && !pop_d) fill_d = fill_q + (AW+1)'(1);
    else if (!push_ok_d && pop_d) fill_d = fill_q - (AW+1)'(1);
  end

  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst && push_ok_d) mem_q[wr_ptr_q] <= push_data_q;
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      pack_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      pres_q      <= 1'b0;
      app_en_q    <= 1'b0;
      wren_q      <= 1'b0;
      wdf_data_q  <= '0;
      addr_q      <= BASE_ADDR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      done_q <= 1'b0;
      push_q <= 1'b0;

      // packed-word FIFO
      if (push_ok_d) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_d) rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      if (push_q && !push_ok_d) overflow_q <= 1'b1;

      // write side: head word stays in the FIFO until both channels accept it
      if (pop_d) begin
        pres_q   <= 1'b0;
        app_en_q <= 1'b0;
        wren_q   <= 1'b0;
        addr_q   <= addr_q + 28'(ADDR_STEP);
        words_q  <= words_q + 16'd1;
      end else if (pres_q) begin
        if (app_en_q && mig.app_rdy) app_en_q <= 1'b0;
        if (wren_q && mig.app_wdf_rdy) wren_q <= 1'b0;
      end else if (state_q != S_IDLE && fill_q != '0) begin
        pres_q     <= 1'b1;
        app_en_q   <= 1'b1;
        wren_q     <= 1'b1;
        wdf_data_q <= mem_q[rd_ptr_q];
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start && init_calib_complete && !busy_q) begin
            if (sample_count != 16'd0) begin
              state_q    <= S_CAPTURE;
              busy_q     <= 1'b1;
              cnt_q      <= sample_count;
              overflow_q <= 1'b0;
              words_q    <= '0;
              addr_q     <= BASE_ADDR;
              pack_q     <= '0;
              slot_q     <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (adc_valid) begin
            cnt_q <= cnt_q - 16'd1;
            if (slot_q == 3'd7 || cnt_q == 16'd1) begin
              push_q      <= 1'b1;
              push_data_q <= word_d;
              pack_q      <= '0;
              slot_q      <= '0;
            end else begin
              pack_q <= word_d;
              slot_q <= slot_q + 3'd1;
            end
            if (cnt_q == 16'd1) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // push_q covers the last word still on its way into the FIFO
          if (fill_q == '0 && !pres_q && !push_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mig.app_addr     = addr_q;
  assign mig.app_cmd      = 3'b000;
  assign mig.app_en       = app_en_q;
  assign mig.app_wdf_data = wdf_data_q;
  assign mig.app_wdf_wren = wren_q;
  assign mig.app_wdf_end  = wren_q;

  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_adc_ddr3_writer.sv
// Directed bench for adc_ddr3_writer (FIFO_DEPTH=4). Inputs change 1 time unit
// after the rising edge; a negedge monitor logs MIG handshakes and done pulses.
module tb_adc_ddr3_writer;

  logic        ui_clk = 1'b0;
  logic        ui_clk_sync_rst;
  logic        init_calib_complete;
  logic        start;
  logic [15:0] sample_count;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        busy, done, overflow;
  logic [15:0] words_written;

  adc_ddr3_writer_if mig ();

  adc_ddr3_writer #(.FIFO_DEPTH(4)) dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .start               (start),
    .sample_count        (sample_count),
    .adc_data            (adc_data),
    .adc_valid           (adc_valid),
    .mig                 (mig.master),
    .busy                (busy),
    .done                (done),
    .overflow            (overflow),
    .words_written       (words_written)
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int errors = 0;

  logic [27:0]  addr_log[$];
  logic [127:0] data_log[$];
  int en_cycles, wren_cycles, done_cnt, stab_err;
  int cyc, cmd_cyc, wdf_cyc, last_acc_cyc, done_cyc;
  logic        stall_c, stall_d;
  logic [27:0]  prev_addr;
  logic [127:0] prev_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] qdata(input int i);
    if (i < data_log.size()) return data_log[i];
    return 'x;
  endfunction

  function automatic logic [27:0] qaddr(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return 'x;
  endfunction

  always @(negedge ui_clk) begin
    cyc = cyc + 1;
    if (ui_clk_sync_rst) begin
      stall_c = 1'b0;
      stall_d = 1'b0;
    end else begin
      if (stall_c && (!mig.app_en || mig.app_addr != prev_addr)) stab_err = stab_err + 1;
      if (stall_d && (!mig.app_wdf_wren || mig.app_wdf_data != prev_data)) stab_err = stab_err + 1;
      if (mig.app_wdf_end != mig.app_wdf_wren || mig.app_cmd != 3'b000) stab_err = stab_err + 1;
      if (mig.app_en) en_cycles = en_cycles + 1;
      if (mig.app_wdf_wren) wren_cycles = wren_cycles + 1;
      if (mig.app_en && mig.app_rdy) begin
        addr_log.push_back(mig.app_addr);
        cmd_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (mig.app_wdf_wren && mig.app_wdf_rdy) begin
        data_log.push_back(mig.app_wdf_data);
        wdf_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      stall_c   = mig.app_en && !mig.app_rdy;
      stall_d   = mig.app_wdf_wren && !mig.app_wdf_rdy;
      prev_addr = mig.app_addr;
      prev_data = mig.app_wdf_data;
    end
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
    en_cycles = 0; wren_cycles = 0; done_cnt = 0; stab_err = 0;
    cmd_cyc = 0; wdf_cyc = 0; last_acc_cyc = 0; done_cyc = 0;
  endtask

  task automatic do_start(input logic [15:0] n);
    sample_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [11:0] base);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = base + 12'(i);
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk(tag, (k < budget), 1);
    tick();
    tick();
  endtask

  initial begin
    cyc = 0; stall_c = 0; stall_d = 0; prev_addr = '0; prev_data = '0;
    clear_log();
    ui_clk_sync_rst = 1'b1;
    init_calib_complete = 1'b1;
    start = 1'b0; sample_count = '0; adc_data = '0; adc_valid = 1'b0;
    mig.app_rdy = 1'b1; mig.app_wdf_rdy = 1'b1;
    repeat (3) tick();
    ui_clk_sync_rst = 1'b0;
    tick();

    // reset state
    chk("rst_addr", mig.app_addr, 28'h0);
    chk("rst_en", mig.app_en, 0);
    chk("rst_wren", mig.app_wdf_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_words", words_written, 0);

    // 1: 16 samples, always ready
    clear_log();
    do_start(16);
    chk("t1_busy", busy, 1);
    feed(16, 12'h000);
    wait_done("t1_timeout", 50);
    chk("t1_nwr", addr_log.size(), 2);
    chk("t1_addr0", qaddr(0), 28'h0);
    chk("t1_addr1", qaddr(1), 28'h8);
    chk("t1_data0", qdata(0), 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("t1_data1", qdata(1), 128'h000F_000E_000D_000C_000B_000A_0009_0008);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_words", words_written, 2);
    chk("t1_busy_end", busy, 0);
    chk("t1_ovf", overflow, 0);
    chk("t1_stable", stab_err, 0);

    // 2: partial last word
    clear_log();
    do_start(10);
    feed(10, 12'h100);
    wait_done("t2_timeout", 50);
    chk("t2_nwr", data_log.size(), 2);
    chk("t2_data0", qdata(0), 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("t2_data1", qdata(1), 128'h0000_0000_0000_0000_0000_0000_0109_0108);
    chk("t2_done_after", (done_cyc > last_acc_cyc), 1);
    chk("t2_words", words_written, 2);

    // 3: command channel stalls 5 cycles, data accepted at once
    clear_log();
    mig.app_rdy = 1'b0;
    do_start(8);
    feed(8, 12'h020);
    begin
      int k = 0;
      while (!mig.app_en && k < 20) begin
        tick();
        k++;
      end
      chk("t3_en_timeout", (k < 20), 1);
    end
    repeat (5) tick();
    mig.app_rdy = 1'b1;
    wait_done("t3_timeout", 30);
    chk("t3_en_cycles", en_cycles, 6);
    chk("t3_wren_cycles", wren_cycles, 1);
    chk("t3_wdf_first", (wdf_cyc < cmd_cyc), 1);
    chk("t3_stable", stab_err, 0);
    chk("t3_addr0", qaddr(0), 28'h0);
    chk("t3_data0", qdata(0), 128'h0027_0026_0025_0024_0023_0022_0021_0020);
    chk("t3_words", words_written, 1);

    // 4: overflow with MIG not ready; 6 words packed, 4 fit
    clear_log();
    mig.app_rdy = 1'b0; mig.app_wdf_rdy = 1'b0;
    do_start(48);
    feed(48, 12'h000);
    repeat (4) tick();
    chk("t4_ovf", overflow, 1);
    chk("t4_words_held", words_written, 0);
    chk("t4_en_held", mig.app_en, 1);
    mig.app_rdy = 1'b1; mig.app_wdf_rdy = 1'b1;
    wait_done("t4_timeout", 100);
    chk("t4_nwr", addr_log.size(), 4);
    chk("t4_addr3", qaddr(3), 28'h18);
    chk("t4_data0", qdata(0), 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("t4_data3", qdata(3), 128'h001F_001E_001D_001C_001B_001A_0019_0018);
    chk("t4_words", words_written, 4);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_stable", stab_err, 0);

    // 5: zero-length run, then start while not calibrated
    clear_log();
    do_start(0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    tick();
    chk("t5_done_gone", done, 0);
    init_calib_complete = 1'b0;
    do_start(8);
    feed(8, 12'h000);
    repeat (5) tick();
    chk("t5_nocal_busy", busy, 0);
    chk("t5_en_cycles", en_cycles, 0);
    chk("t5_done_cnt", done_cnt, 1);
    init_calib_complete = 1'b1;

    // 6: reset after 3 words, then a clean 8-word run
    clear_log();
    do_start(64);
    for (int i = 0; i < 64; i++) begin
      if (addr_log.size() >= 3) break;
      adc_valid = 1'b1;
      adc_data  = 12'(i);
      tick();
    end
    chk("t6_reached3", (addr_log.size() >= 3), 1);
    ui_clk_sync_rst = 1'b1;
    tick();
    chk("t6_rst_en", mig.app_en, 0);
    chk("t6_rst_wren", mig.app_wdf_wren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", mig.app_addr, 28'h0);
    chk("t6_rst_words", words_written, 0);
    ui_clk_sync_rst = 1'b0;
    en_cycles = 0; done_cnt = 0;
    repeat (6) tick();
    adc_valid = 1'b0;
    chk("t6_no_en", en_cycles, 0);
    chk("t6_no_done", done_cnt, 0);
    clear_log();
    do_start(64);
    feed(64, 12'h000);
    wait_done("t6_timeout", 100);
    chk("t6_nwr", addr_log.size(), 8);
    chk("t6_addr0", qaddr(0), 28'h0);
    chk("t6_addr7", qaddr(7), 28'h38);
    chk("t6_data7", qdata(7), 128'h003F_003E_003D_003C_003B_003A_0039_0038);
    chk("t6_words", words_written, 8);
    chk("t6_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
